// File: rtl/dec_ctrl_hazard_pkg.sv
// rtl/dec_ctrl_hazard_pkg.sv - opcode/funct constants, ALU and branch encodings, tracker entry type
package dec_ctrl_hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_LUI  = 5'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_J    = 4'd3,
        BR_JR   = 4'd4
    } br_op_e;

    typedef struct packed {
        logic       we;
        logic [4:0] wra;
        logic       is_load;
    } dst_t;

endpackage

// File: rtl/dec_ctrl_hazard_if.sv
// rtl/dec_ctrl_hazard_if.sv - decode-stage bus between IF/ID, register file and ID/EX
interface dec_ctrl_hazard_if;
    logic [31:0] i_inst;
    logic [31:0] i_rd1;
    logic [31:0] i_rd2;
    logic [31:0] i_aluOutE;
    logic [31:0] i_rstM;
    logic [31:0] i_rstW;
    logic        o_regWe;
    logic        o_dMemWe;
    logic        o_sWRD;
    logic        o_sA;
    logic        o_sB;
    logic        o_sByte;
    logic [4:0]  o_aluOP;
    logic [3:0]  o_brOP;
    logic [4:0]  o_WRA;
    logic [31:0] o_num;
    logic [25:0] o_targetPC;
    logic [31:0] o_rd1;
    logic [31:0] o_rd2;
    logic        o_pause;

    modport master (
        output i_inst, i_rd1, i_rd2, i_aluOutE, i_rstM, i_rstW,
        input  o_regWe, o_dMemWe, o_sWRD, o_sA, o_sB, o_sByte, o_aluOP, o_brOP,
               o_WRA, o_num, o_targetPC, o_rd1, o_rd2, o_pause
    );

    modport slave (
        input  i_inst, i_rd1, i_rd2, i_aluOutE, i_rstM, i_rstW,
        output o_regWe, o_dMemWe, o_sWRD, o_sA, o_sB, o_sByte, o_aluOP, o_brOP,
               o_WRA, o_num, o_targetPC, o_rd1, o_rd2, o_pause
    );
endinterface

// File: rtl/dec_fwd_unit.sv
// rtl/dec_fwd_unit.sv - E/M/W destination tracker, operand forwarding and load-use stall
module dec_fwd_unit
    import dec_ctrl_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] alu_out_e,
    input  logic [31:0] rst_m,
    input  logic [31:0] rst_w,
    input  dst_t        dec_dst,
    output logic [31:0] fwd_rd1,
    output logic [31:0] fwd_rd2,
    output logic        pause
);

    dst_t st_e, st_m, st_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_e <= '0;
            st_m <= '0;
            st_w <= '0;
        end else begin
            st_w <= st_m;
            st_m <= st_e;
            st_e <= pause ? '0 : dec_dst;
        end
    end

    // A load in EX has no result yet, so it falls through to older stages; the stall covers it.
    function automatic logic [31:0] pick(input logic [4:0] addr, input logic [31:0] rf,
                                         input dst_t e, input dst_t m, input dst_t w,
                                         input logic [31:0] ve, input logic [31:0] vm,
                                         input logic [31:0] vw);
        if (addr == 5'd0)                               return rf;
        if (e.we && e.wra == addr && !e.is_load)        return ve;
        if (m.we && m.wra == addr)                      return vm;
        if (w.we && w.wra == addr)                      return vw;
        return rf;
    endfunction

    always_comb begin
        fwd_rd1 = pick(src1, rd1, st_e, st_m, st_w, alu_out_e, rst_m, rst_w);
        fwd_rd2 = pick(src2, rd2, st_e, st_m, st_w, alu_out_e, rst_m, rst_w);
        pause   = st_e.we && st_e.is_load && (st_e.wra != 5'd0) &&
                  ((st_e.wra == src1) || (st_e.wra == src2));
    end

endmodule

// File: rtl/dec_ctrl_hazard.sv
// rtl/dec_ctrl_hazard.sv - decode-stage control: instruction decode, immediate extension, hazards
module dec_ctrl_hazard
    import dec_ctrl_hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    dec_ctrl_hazard_if.slave bus
);

    logic [5:0]  op, fn;
    logic [15:0] imm;
    logic        valid, reg_we, dmem_we, s_wrd, s_a, s_b, s_byte, use_shamt, zext, is_load;
    alu_op_e     alu;
    br_op_e      br;
    logic [4:0]  wra;
    logic [31:0] num;
    dst_t        dec_dst;

    assign op  = bus.i_inst[31:26];
    assign fn  = bus.i_inst[5:0];
    assign imm = bus.i_inst[15:0];

    always_comb begin
        valid = 1'b1; reg_we = 1'b0; dmem_we = 1'b0; s_wrd = 1'b0; s_a = 1'b0;
        s_b = 1'b0; s_byte = 1'b0; use_shamt = 1'b0; zext = 1'b0; is_load = 1'b0;
        alu = ALU_ADD; br = BR_NONE; wra = bus.i_inst[20:16];
        case (op)
            OP_RTYPE: begin
                wra    = bus.i_inst[15:11];
                reg_we = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: alu = ALU_ADD;
                    FN_SUB, FN_SUBU: alu = ALU_SUB;
                    FN_AND:          alu = ALU_AND;
                    FN_OR:           alu = ALU_OR;
                    FN_XOR:          alu = ALU_XOR;
                    FN_NOR:          alu = ALU_NOR;
                    FN_SLT:          alu = ALU_SLT;
                    FN_SLTU:         alu = ALU_SLTU;
                    FN_SLLV:         alu = ALU_SLL;
                    FN_SRLV:         alu = ALU_SRL;
                    FN_SRAV:         alu = ALU_SRA;
                    FN_SLL: begin alu = ALU_SLL; s_a = 1'b1; use_shamt = 1'b1; end
                    FN_SRL: begin alu = ALU_SRL; s_a = 1'b1; use_shamt = 1'b1; end
                    FN_SRA: begin alu = ALU_SRA; s_a = 1'b1; use_shamt = 1'b1; end
                    FN_JR:  begin reg_we = 1'b0; br = BR_JR; end
                    default: valid = 1'b0;
                endcase
            end
            OP_J:     br = BR_J;
            OP_BEQ:   begin alu = ALU_SUB; br = BR_BEQ; end
            OP_BNE:   begin alu = ALU_SUB; br = BR_BNE; end
            OP_ADDI, OP_ADDIU: begin reg_we = 1'b1; s_b = 1'b1; end
            OP_SLTI:  begin reg_we = 1'b1; s_b = 1'b1; alu = ALU_SLT; end
            OP_SLTIU: begin reg_we = 1'b1; s_b = 1'b1; alu = ALU_SLTU; end
            OP_ANDI:  begin reg_we = 1'b1; s_b = 1'b1; alu = ALU_AND; zext = 1'b1; end
            OP_ORI:   begin reg_we = 1'b1; s_b = 1'b1; alu = ALU_OR;  zext = 1'b1; end
            OP_XORI:  begin reg_we = 1'b1; s_b = 1'b1; alu = ALU_XOR; zext = 1'b1; end
            OP_LUI:   begin reg_we = 1'b1; s_b = 1'b1; alu = ALU_LUI; zext = 1'b1; end
            OP_LW:    begin reg_we = 1'b1; s_b = 1'b1; s_wrd = 1'b1; is_load = 1'b1; end
            OP_LB:    begin reg_we = 1'b1; s_b = 1'b1; s_wrd = 1'b1; is_load = 1'b1; s_byte = 1'b1; end
            OP_SW:    begin dmem_we = 1'b1; s_b = 1'b1; end
            OP_SB:    begin dmem_we = 1'b1; s_b = 1'b1; s_byte = 1'b1; end
            default:  valid = 1'b0;
        endcase
    end

    always_comb begin
        if (use_shamt)  num = {27'b0, bus.i_inst[10:6]};
        else if (zext)  num = {16'b0, imm};
        else            num = {{16{imm[15]}}, imm};
    end

    // Unrecognised encodings collapse to a full NOP so nothing downstream acts on them.
    always_comb begin
        bus.o_regWe    = valid & reg_we;
        bus.o_dMemWe   = valid & dmem_we;
        bus.o_sWRD     = valid & s_wrd;
        bus.o_sA       = valid & s_a;
        bus.o_sB       = valid & s_b;
        bus.o_sByte    = valid & s_byte;
        bus.o_aluOP    = valid ? alu : ALU_ADD;
        bus.o_brOP     = valid ? br  : BR_NONE;
        bus.o_WRA      = valid ? wra : 5'd0;
        bus.o_num      = valid ? num : 32'd0;
        bus.o_targetPC = bus.i_inst[25:0];
        dec_dst.we      = valid & reg_we;
        dec_dst.wra     = valid ? wra : 5'd0;
        dec_dst.is_load = valid & is_load;
    end

    dec_fwd_unit u_fwd (
        .clk       (clk),
        .rst       (rst),
        .src1      (bus.i_inst[25:21]),
        .src2      (bus.i_inst[20:16]),
        .rd1       (bus.i_rd1),
        .rd2       (bus.i_rd2),
        .alu_out_e (bus.i_aluOutE),
        .rst_m     (bus.i_rstM),
        .rst_w     (bus.i_rstW),
        .dec_dst   (dec_dst),
        .fwd_rd1   (bus.o_rd1),
        .fwd_rd2   (bus.o_rd2),
        .pause     (bus.o_pause)
    );

endmodule

// File: tb/tb_dec_ctrl_hazard.sv
// tb/tb_dec_ctrl_hazard.sv - directed and randomized check of dec_ctrl_hazard against a reference model
module tb_dec_ctrl_hazard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dec_ctrl_hazard_if bus ();

    dec_ctrl_hazard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        valid, we, mwe, swrd, sa, sb, sbyte;
        logic [4:0]  alu;
        logic [3:0]  br;
        logic [4:0]  wra;
        logic [31:0] num;
        logic        num_chk, ld;
    } exp_t;

    // Reference tracker: index 0 = EX, 1 = MEM, 2 = WB
    logic       m_we  [3];
    logic [4:0] m_wra [3];
    logic       m_ld  [3];
    exp_t       ex;
    logic       exp_pause;

    int ops [19] = '{0, 0, 0, 0, 2, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 32, 35, 40, 43};
    int fns [17] = '{0, 2, 3, 4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 0;
            6'h22, 6'h23: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h26: return 4;
            6'h27: return 5;
            6'h2A: return 6;
            6'h2B: return 7;
            6'h00, 6'h04: return 8;
            6'h02, 6'h06: return 9;
            6'h03, 6'h07: return 10;
            6'h08: return 100;
            default: return -1;
        endcase
    endfunction

    function automatic int i_alu(input logic [5:0] op);
        case (op)
            6'h08, 6'h09, 6'h20, 6'h23, 6'h28, 6'h2B, 6'h02: return 0;
            6'h04, 6'h05: return 1;
            6'h0A: return 6;
            6'h0B: return 7;
            6'h0C: return 2;
            6'h0D: return 3;
            6'h0E: return 4;
            6'h0F: return 11;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t ref_dec(input logic [31:0] in);
        exp_t e;
        int a;
        logic [5:0] op = in[31:26];
        logic [5:0] fn = in[5:0];
        logic [31:0] se = {{16{in[15]}}, in[15:0]};
        logic [31:0] ze = {16'h0, in[15:0]};
        e = '0;
        if (op == 6'h00) begin
            a = r_alu(fn);
            e.valid = (a >= 0);
            e.wra = in[15:11];
            if (a == 100) e.br = 4'd4;
            else if (a >= 0) begin
                e.we  = 1'b1;
                e.alu = a[4:0];
                if (fn inside {6'h00, 6'h02, 6'h03}) begin
                    e.sa = 1'b1;
                    e.num = {27'h0, in[10:6]};
                    e.num_chk = 1'b1;
                end
            end
        end else begin
            a = i_alu(op);
            e.valid = (a >= 0);
            e.wra = in[20:16];
            if (a >= 0) begin
                e.alu   = a[4:0];
                e.ld    = op inside {6'h20, 6'h23};
                e.mwe   = op inside {6'h28, 6'h2B};
                e.swrd  = e.ld;
                e.sbyte = op inside {6'h20, 6'h28};
                e.we    = op inside {[6'h08:6'h0F], 6'h20, 6'h23};
                e.sb    = e.we | e.mwe;
                e.br    = (op == 6'h04) ? 4'd1 : (op == 6'h05) ? 4'd2 : (op == 6'h02) ? 4'd3 : 4'd0;
                if (op inside {[6'h0C:6'h0F]}) begin e.num = ze; e.num_chk = 1'b1; end
                else if (op != 6'h02) begin e.num = se; e.num_chk = 1'b1; end
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
        if (m_we[0] && m_wra[0] == a && !m_ld[0]) return bus.i_aluOutE;
        if (m_we[1] && m_wra[1] == a) return bus.i_rstM;
        if (m_we[2] && m_wra[2] == a) return bus.i_rstW;
        return rf;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        logic [5:0] op, fn;
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(0, 63));
        else                            op = 6'(ops[$urandom_range(0, 18)]);
        if ($urandom_range(0, 15) == 0) fn = 6'($urandom_range(0, 63));
        else                            fn = 6'(fns[$urandom_range(0, 16)]);
        if (op == 6'h00) return {op, rs, rt, rd, r[10:6], fn};
        return {op, rs, rt, r[15:0]};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic r);
        @(negedge clk);
        rst           = r;
        bus.i_inst    = inst;
        bus.i_rd1     = $urandom;
        bus.i_rd2     = $urandom;
        bus.i_aluOutE = $urandom;
        bus.i_rstM    = $urandom;
        bus.i_rstW    = $urandom;
        #1;
    endtask

    task automatic check_all();
        logic [4:0] rs = bus.i_inst[25:21];
        logic [4:0] rt = bus.i_inst[20:16];
        ex = ref_dec(bus.i_inst);
        exp_pause = m_we[0] && m_ld[0] && (m_wra[0] != 5'd0) && (m_wra[0] == rs || m_wra[0] == rt);
        check("regWe",   32'(bus.o_regWe),  32'(ex.we));
        check("dMemWe",  32'(bus.o_dMemWe), 32'(ex.mwe));
        check("sWRD",    32'(bus.o_sWRD),   32'(ex.swrd));
        check("sA",      32'(bus.o_sA),     32'(ex.sa));
        check("sB",      32'(bus.o_sB),     32'(ex.sb));
        check("sByte",   32'(bus.o_sByte),  32'(ex.sbyte));
        check("aluOP",   32'(bus.o_aluOP),  32'(ex.alu));
        check("brOP",    32'(bus.o_brOP),   32'(ex.br));
        if (ex.valid)   check("WRA", 32'(bus.o_WRA), 32'(ex.wra));
        if (ex.num_chk) check("num", bus.o_num, ex.num);
        check("targetPC", 32'(bus.o_targetPC), 32'(bus.i_inst[25:0]));
        check("rd1",   bus.o_rd1, ref_fwd(rs, bus.i_rd1));
        check("rd2",   bus.o_rd2, ref_fwd(rt, bus.i_rd2));
        check("pause", 32'(bus.o_pause), 32'(exp_pause));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin m_we[i] = 0; m_wra[i] = 0; m_ld[i] = 0; end
        end else begin
            for (int i = 2; i > 0; i--) begin
                m_we[i] = m_we[i-1]; m_wra[i] = m_wra[i-1]; m_ld[i] = m_ld[i-1];
            end
            m_we[0]  = exp_pause ? 1'b0 : ex.we;
            m_wra[0] = exp_pause ? 5'd0 : ex.wra;
            m_ld[0]  = exp_pause ? 1'b0 : ex.ld;
        end
    endtask

    task automatic step(input logic [31:0] inst, input logic r);
        drive(inst, r);
        check_all();
        advance();
    endtask

    initial begin
        logic [31:0] inst;
        bus.i_inst = 32'h0; bus.i_rd1 = 32'h0; bus.i_rd2 = 32'h0;
        bus.i_aluOutE = 32'h0; bus.i_rstM = 32'h0; bus.i_rstW = 32'h0;
        for (int i = 0; i < 3; i++) begin m_we[i] = 0; m_wra[i] = 0; m_ld[i] = 0; end
        @(posedge clk);

        // reset state: lw depending on $1 must neither stall nor forward
        drive(32'h8C270000, 1'b0);
        check_all();
        check("rst_pause", 32'(bus.o_pause), 32'd0);
        check("rst_rd1", bus.o_rd1, bus.i_rd1);
        advance();

        step(32'h00000000, 1'b1);
        drive(32'h2022FFFC, 1'b0);
        check_all();
        check("addi_num", bus.o_num, 32'hFFFFFFFC);
        check("addi_wra", 32'(bus.o_WRA), 32'd2);
        check("addi_sb",  32'(bus.o_sB), 32'd1);
        advance();
        drive(32'h34038000, 1'b0);
        check_all();
        check("ori_num", bus.o_num, 32'h00008000);
        advance();
        drive(32'h000521C0, 1'b0);
        check_all();
        check("sll_sa",  32'(bus.o_sA), 32'd1);
        check("sll_alu", 32'(bus.o_aluOP), 32'd8);
        check("sll_num", bus.o_num, 32'd7);
        check("sll_wra", 32'(bus.o_WRA), 32'd4);
        advance();

        // EX forward wins over MEM and WB
        step(32'h00430820, 1'b0);
        step(32'h00430820, 1'b0);
        step(32'h00430820, 1'b0);
        drive(32'h00213020, 1'b0);
        bus.i_aluOutE = 32'h11; bus.i_rstM = 32'h22; bus.i_rstW = 32'h33;
        #1;
        check_all();
        check("exfwd_rd1", bus.o_rd1, 32'h11);
        check("exfwd_rd2", bus.o_rd2, 32'h11);
        check("exfwd_pause", 32'(bus.o_pause), 32'd0);
        advance();

        // load-use: one stall, then MEM forward
        step(32'h00000000, 1'b1);
        step(32'h8C270000, 1'b0);
        drive(32'h00E04021, 1'b0);
        check_all();
        check("lu_pause1", 32'(bus.o_pause), 32'd1);
        advance();
        drive(32'h00E04021, 1'b0);
        check_all();
        check("lu_pause2", 32'(bus.o_pause), 32'd0);
        check("lu_rd1", bus.o_rd1, bus.i_rstM);
        advance();

        // writes to $0 are never forwarded
        step(32'h20000005, 1'b0);
        drive(32'h00004820, 1'b0);
        check_all();
        check("zero_rd1", bus.o_rd1, bus.i_rd1);
        advance();

        // reset during a stall
        step(32'h8C270000, 1'b0);
        step(32'h00E04021, 1'b1);
        drive(32'h00E04021, 1'b0);
        check_all();
        check("rststall_pause", 32'(bus.o_pause), 32'd0);
        check("rststall_rd1", bus.o_rd1, bus.i_rd1);
        advance();

        // unknown opcode
        drive(32'hFC000000, 1'b0);
        check_all();
        check("unk_regwe", 32'(bus.o_regWe), 32'd0);
        check("unk_br",    32'(bus.o_brOP), 32'd0);
        check("unk_alu",   32'(bus.o_aluOP), 32'd0);
        advance();

        inst = rand_inst();
        for (int n = 0; n < 400; n++) begin
            logic r = ($urandom_range(0, 39) == 0);
            step(inst, r);
            if (!(exp_pause && !r)) inst = rand_inst();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dec_ctrl_hazard.md
# dec_ctrl_hazard

Decode-stage control block of the 5-stage MIPS-subset pipeline. Combines three functions: instruction decode into datapath control signals, immediate selection/extension, and operand forwarding with load-use stall detection. Sits between the IF/ID register and the ID/EX register. It consumes the latched instruction and the register-file read data, and drives the ID/EX control and operand fields plus the stall request.

## Interface
- No parameters.
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_inst  in  32  instruction latched in the decode stage
- i_rd1, i_rd2  in  32  register-file read data for inst[25:21] and inst[20:16]
- i_aluOutE  in  32  result of the instruction now in EX
- i_rstM  in  32  write-back value of the instruction now in MEM
- i_rstW  in  32  write-back value of the instruction now in WB
- o_regWe  out  1  instruction writes a register
- o_dMemWe  out  1  store
- o_sWRD  out  1  write-back data select: 0 = ALU, 1 = memory
- o_sA  out  1  ALU A source: 0 = rs data, 1 = o_num (shift amount)
- o_sB  out  1  ALU B source: 0 = rt data, 1 = o_num
- o_sByte  out  1  byte access (lb/sb)
- o_aluOP  out  5  ALU operation
- o_brOP  out  4  branch/jump operation
- o_WRA  out  5  destination register
- o_num  out  32  extended immediate
- o_targetPC  out  26  inst[25:0]
- o_rd1, o_rd2  out  32  forwarded operands
- o_pause  out  1  load-use stall request

## Operation
- **Supported instructions:**
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr.
  - I-type: addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, lb, sw, sb, beq, bne.
  - J-type: j.
- Any other opcode or funct produces all controls 0 (NOP).
- **aluOP encoding:** ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11.
  - add/addu/addi/addiu/loads/stores use ADD; beq/bne use SUB.
  - Shifts shift B by A[4:0].
- **brOP encoding:** NONE=0, BEQ=1, BNE=2, J=3, JR=4.
- **Control outputs:**
  - o_regWe = 1 for all ALU ops, immediates, lui and loads.
  - o_dMemWe = 1 for sw/sb.
  - o_sWRD = 1 for lw/lb.
  - o_sByte = 1 for lb/sb.
- **Destination:** o_WRA = rd (inst[15:11]) for R-type, otherwise rt (inst[20:16]).
- **ALU source selects:**
  - o_sA = 1 only for sll/srl/sra.
  - o_sB = 1 for all I-type ALU ops, lui, loads and stores.
- **Immediate:**
  - sll/srl/sra select {27'b0, inst[10:6]}.
  - Otherwise inst[15:0] is used:
    - sign-extended for addi, addiu, slti, sltiu, loads, stores, beq, bne;
    - zero-extended for andi, ori, xori, lui.
- **Destination tracker:** three stages E, M, W, each holding {we, wra, isLoad}.
  - Every clock: W←M, M←E.
  - E←decoded {o_regWe, o_WRA, load} when o_pause = 0; E←bubble (we = 0) when o_pause = 1.
- **Forwarding for o_rd1 (source inst[25:21]); o_rd2 identical with inst[20:16]:**
  - Address 0 is never forwarded; the output is i_rd1.
  - Otherwise the first match in this order wins:
    1. E.we & E.wra==addr & !E.isLoad → i_aluOutE
    2. M.we & M.wra==addr → i_rstM
    3. W.we & W.wra==addr → i_rstW
    4. else i_rd1
- **Stall:** o_pause = E.we & E.isLoad & E.wra≠0 & (E.wra==inst[25:21] | E.wra==inst[20:16]).
  - The check is conservative: both fields are compared regardless of instruction format.
  - The upstream pipeline holds IF/ID while o_pause = 1.

## Timing
- Decode, immediate, forwarding and o_pause are purely combinational, with zero latency.
- The tracker updates on the rising clk edge.
- **Reset:** rst=1 at an edge clears E, M and W to bubble (we = 0, wra = 0, isLoad = 0). After reset:
  - o_pause = 0;
  - o_rd1/o_rd2 = i_rd1/i_rd2;
  - decode outputs still follow i_inst.
- **Load-use:** a load followed by a dependent instruction stalls exactly 1 cycle. In the next cycle the load sits in M and the value is taken from i_rstM.
- Reset asserted mid-stall drops the stall at the next edge.

## Structure
- Shared package: opcode and funct constants, aluOP and brOP encodings.
- One sub-module, dec_fwd_unit: the tracker, forwarding muxes and stall logic.
- Decode and extension stay in the top module.

## Test plan
- **addi:** i_inst=addi $2,$1,-4 (0x2022FFFC) → regWe=1, sB=1, aluOP=0, WRA=2, num=0xFFFFFFFC.
- **ori:** i_inst=ori $3,$0,0x8000 → num=0x00008000. **sll:** sll $4,$5,7 → sA=1, aluOP=8, WRA=4, num=7.
- **EX forward:** add $1,.. then add $6,$1,$1 with i_aluOutE=0x11 → o_rd1=o_rd2=0x11, pause=0.
  - With M and W also matching (values 0x22, 0x33), E still wins.
- **Load-use:** lw $7 then addu $8,$7,$0 → pause=1 for one cycle.
  - Next cycle: pause=0 and o_rd1=i_rstM.
- **$0 and reset:** a prior instruction writing $0 → o_rd1=i_rd1.
  - rst for one cycle after a lw → no pause and no forwarding afterwards.
- **Unknown opcode 0x3F:** all controls 0, brOP=0.
